// File: rtl/io_ctrl_multi_if.sv
// Core-side IO bus of the IO-memory controller: one read port and one write port.
interface io_ctrl_multi_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] readaddr;
    logic [DATA_WIDTH-1:0] readdata;
    logic [ADDR_WIDTH-1:0] writeaddr;
    logic [DATA_WIDTH-1:0] writedata;
    logic                  write_en;

    modport master (
        output readaddr, writeaddr, writedata, write_en,
        input  readdata
    );

    modport slave (
        input  readaddr, writeaddr, writedata, write_en,
        output readdata
    );
endinterface

// File: rtl/io_ctrl_multi.sv
// IO-space controller: LED register, synchronised keys/switches with change detect,
// NUM_TIMERS prescaled tick timers and a masked write-1-to-clear interrupt block.
module io_ctrl_multi #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 5,
    parameter int NUM_TIMERS   = 2,
    parameter int NUM_KEYS     = 4,
    parameter int NUM_SWITCHES = 4,
    parameter int NUM_LEDS     = 4,
    parameter int TICK_DIV     = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    io_ctrl_multi_if.slave          bus,
    output logic [NUM_TIMERS:0]     interrupts,
    input  logic [NUM_KEYS-1:0]     keys,
    input  logic [NUM_SWITCHES-1:0] switches,
    output logic [NUM_LEDS-1:0]     leds
);
    localparam int NUM_IN  = NUM_KEYS + NUM_SWITCHES;
    localparam int NUM_IRQ = NUM_TIMERS + 1;
    localparam int PW      = $clog2(TICK_DIV);

    logic [NUM_IN-1:0]     in_s1, in_sync, in_prev;
    logic [NUM_LEDS-1:0]   led_reg;
    logic [NUM_IRQ-1:0]    pend, irq_en, pend_set, pend_clr;
    logic [PW-1:0]         presc;
    logic                  tick;
    logic [DATA_WIDTH-1:0] count  [NUM_TIMERS];
    logic [DATA_WIDTH-1:0] reload [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] run, reload_en, expire, cnt_wr, ctl_wr;
    logic [DATA_WIDTH-1:0] rd_mux;

    assign tick       = (presc == PW'(TICK_DIV - 1));
    assign pend_set   = {expire, in_sync != in_prev};
    assign interrupts = pend & irq_en;
    assign leds       = led_reg;

    always_comb begin
        cnt_wr   = '0;
        ctl_wr   = '0;
        expire   = '0;
        pend_clr = '0;
        if (bus.write_en && bus.writeaddr == ADDR_WIDTH'(2))
            pend_clr = bus.writedata[NUM_IRQ-1:0];
        for (int i = 0; i < NUM_TIMERS; i++) begin
            cnt_wr[i] = bus.write_en && (bus.writeaddr == ADDR_WIDTH'(4 + 2*i));
            ctl_wr[i] = bus.write_en && (bus.writeaddr == ADDR_WIDTH'(5 + 2*i));
            expire[i] = tick && run[i] && (count[i] == DATA_WIDTH'(1));
        end
    end

    // A fresh set event on a pending bit beats a simultaneous W1C of that bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_s1   <= '0;
            in_sync <= '0;
            in_prev <= '0;
            led_reg <= '0;
            irq_en  <= '0;
            pend    <= '0;
            presc   <= '0;
        end else begin
            in_s1   <= {switches, keys};
            in_sync <= in_s1;
            in_prev <= in_sync;
            presc   <= tick ? '0 : presc + PW'(1);
            pend    <= (pend & ~pend_clr) | pend_set;
            if (bus.write_en && bus.writeaddr == ADDR_WIDTH'(1))
                led_reg <= bus.writedata[NUM_LEDS-1:0];
            if (bus.write_en && bus.writeaddr == ADDR_WIDTH'(3))
                irq_en <= bus.writedata[NUM_IRQ-1:0];
        end
    end

    // Register writes are applied after the tick update so software always wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run       <= '0;
            reload_en <= '0;
            for (int i = 0; i < NUM_TIMERS; i++) begin
                count[i]  <= '0;
                reload[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                if (tick && run[i]) begin
                    if (count[i] > DATA_WIDTH'(1)) begin
                        count[i] <= count[i] - DATA_WIDTH'(1);
                    end else if (count[i] == DATA_WIDTH'(1)) begin
                        if (reload_en[i]) begin
                            count[i] <= reload[i];
                        end else begin
                            count[i] <= '0;
                            run[i]   <= 1'b0;
                        end
                    end
                end
                if (cnt_wr[i]) begin
                    count[i]  <= bus.writedata;
                    reload[i] <= bus.writedata;
                end
                if (ctl_wr[i]) begin
                    run[i]       <= bus.writedata[0];
                    reload_en[i] <= bus.writedata[1];
                end
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.readaddr)
            ADDR_WIDTH'(0): rd_mux = DATA_WIDTH'(in_sync);
            ADDR_WIDTH'(1): rd_mux = DATA_WIDTH'(led_reg);
            ADDR_WIDTH'(2): rd_mux = DATA_WIDTH'(pend);
            ADDR_WIDTH'(3): rd_mux = DATA_WIDTH'(irq_en);
            default: begin
                for (int i = 0; i < NUM_TIMERS; i++) begin
                    if (bus.readaddr == ADDR_WIDTH'(4 + 2*i))
                        rd_mux = count[i];
                    if (bus.readaddr == ADDR_WIDTH'(5 + 2*i))
                        rd_mux = DATA_WIDTH'({reload_en[i], run[i]});
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            bus.readdata <= '0;
        else
            bus.readdata <= rd_mux;
    end
endmodule

// File: tb/tb_io_ctrl_multi.sv
// Bench for io_ctrl_multi: directed bus traffic, a cycle-level behavioural model
// compared every cycle, and hand-computed expectations at key points.
module tb_io_ctrl_multi;
    localparam int DW = 8;
    localparam int AW = 5;
    localparam int NT = 2;
    localparam int NK = 4;
    localparam int NS = 4;
    localparam int NL = 4;
    localparam int TD = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NK-1:0] keys;
    logic [NS-1:0] switches;
    logic [NL-1:0] leds;
    logic [NT:0]   interrupts;

    io_ctrl_multi_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    io_ctrl_multi #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_TIMERS(NT), .NUM_KEYS(NK),
        .NUM_SWITCHES(NS), .NUM_LEDS(NL), .TICK_DIV(TD)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .interrupts(interrupts),
        .keys(keys), .switches(switches), .leds(leds)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    bit chk_on = 1'b0;

    // Behavioural model state: plain integers, tick derived from the cycle count.
    int         m_cyc;
    int         m_cnt [NT];
    int         m_rel [NT];
    bit         m_run [NT];
    bit         m_rl  [NT];
    logic [7:0] m_hist [3];
    logic [3:0] m_led;
    logic [2:0] m_pend, m_en, m_set, m_w1c;
    logic [7:0] exp_rd;
    bit         m_tick;
    int         m_t;

    function automatic logic [7:0] model_read(input logic [4:0] a);
        int ai = int'(a);
        if (ai == 0) return m_hist[1];
        if (ai == 1) return {4'h0, m_led};
        if (ai == 2) return {5'h0, m_pend};
        if (ai == 3) return {5'h0, m_en};
        if (ai >= 4 && ai < 4 + 2*NT) begin
            if (ai % 2 == 0) return 8'(m_cnt[(ai-4)/2]);
            return {6'h0, m_rl[(ai-5)/2], m_run[(ai-5)/2]};
        end
        return 8'h00;
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_cyc = 0;
                for (int t = 0; t < NT; t++) begin
                    m_cnt[t] = 0; m_rel[t] = 0; m_run[t] = 1'b0; m_rl[t] = 1'b0;
                end
                for (int h = 0; h < 3; h++) m_hist[h] = 8'h00;
                m_led = '0; m_pend = '0; m_en = '0; exp_rd = 8'h00;
            end else begin
                exp_rd = model_read(bus.readaddr);
                m_tick = (m_cyc % TD) == TD - 1;
                m_cyc++;
                m_set = '0;
                m_set[0] = (m_hist[1] != m_hist[2]);
                m_hist[2] = m_hist[1];
                m_hist[1] = m_hist[0];
                m_hist[0] = {switches, keys};
                for (int t = 0; t < NT; t++) begin
                    if (m_tick && m_run[t] && m_cnt[t] > 0) begin
                        if (m_cnt[t] == 1) begin
                            m_set[t+1] = 1'b1;
                            m_cnt[t] = m_rl[t] ? m_rel[t] : 0;
                            if (!m_rl[t]) m_run[t] = 1'b0;
                        end else begin
                            m_cnt[t]--;
                        end
                    end
                end
                m_w1c = '0;
                if (bus.write_en) begin
                    m_t = int'(bus.writeaddr);
                    if (m_t == 1) m_led = bus.writedata[3:0];
                    else if (m_t == 2) m_w1c = bus.writedata[2:0];
                    else if (m_t == 3) m_en = bus.writedata[2:0];
                    else if (m_t >= 4 && m_t < 4 + 2*NT) begin
                        if (m_t % 2 == 0) begin
                            m_cnt[(m_t-4)/2] = int'(bus.writedata);
                            m_rel[(m_t-4)/2] = int'(bus.writedata);
                        end else begin
                            m_run[(m_t-5)/2] = bus.writedata[0];
                            m_rl[(m_t-5)/2]  = bus.writedata[1];
                        end
                    end
                end
                m_pend = (m_pend & ~m_w1c) | m_set;
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_on && !reset) begin
                check_output("model readdata", 32'(bus.readdata), 32'(exp_rd));
                check_output("model leds", 32'(leds), 32'(m_led));
                check_output("model interrupts", 32'(interrupts), 32'(m_pend & m_en));
            end
        end
    end

    task automatic apply_stimulus(input logic [4:0] addr, input logic [7:0] data);
        bus.writeaddr = addr;
        bus.writedata = data;
        bus.write_en  = 1'b1;
        @(negedge clk);
        bus.write_en  = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [4:0] addr, input logic [7:0] exp);
        bus.readaddr = addr;
        @(negedge clk);
        check_output(name, 32'(bus.readdata), 32'(exp));
    endtask

    task automatic wait_irq(input int idx, input int max_cycles, output bit found);
        found = 1'b0;
        for (int k = 0; k < max_cycles; k++) begin
            @(negedge clk);
            if (interrupts[idx]) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit found;
        reset = 1'b1;
        keys = '0;
        switches = '0;
        bus.readaddr = '0;
        bus.writeaddr = '0;
        bus.writedata = '0;
        bus.write_en = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_on = 1'b1;

        check_output("reset leds", 32'(leds), 0);
        check_output("reset interrupts", 32'(interrupts), 0);
        check_output("reset readdata", 32'(bus.readdata), 0);
        for (int a = 0; a < 8; a++) read_check("reset read", 5'(a), 8'h00);

        apply_stimulus(5'd1, 8'hA5);
        check_output("led drive", 32'(leds), 32'h5);
        read_check("led readback", 5'd1, 8'h05);

        // One-shot timer 0: three ticks then stop.
        apply_stimulus(5'd3, 8'h02);
        apply_stimulus(5'd4, 8'h03);
        bus.readaddr = 5'd4;
        apply_stimulus(5'd5, 8'h01);
        wait_irq(1, 16, found);
        check_output("tmr0 irq within bound", 32'(found), 1);
        read_check("tmr0 pending", 5'd2, 8'h02);
        read_check("tmr0 run cleared", 5'd5, 8'h00);
        read_check("tmr0 count zero", 5'd4, 8'h00);
        apply_stimulus(5'd2, 8'h02);
        check_output("tmr0 w1c", 32'(interrupts), 0);

        // Auto-reload timer 1 over five periods.
        apply_stimulus(5'd3, 8'h04);
        apply_stimulus(5'd6, 8'h02);
        bus.readaddr = 5'd6;
        apply_stimulus(5'd7, 8'h03);
        for (int p = 0; p < 5; p++) begin
            wait_irq(2, 16, found);
            check_output("tmr1 irq period", 32'(found), 1);
            read_check("tmr1 reloaded count", 5'd6, 8'h02);
            apply_stimulus(5'd2, 8'h04);
            check_output("tmr1 w1c", 32'(interrupts[2]), 0);
        end
        apply_stimulus(5'd7, 8'h00);

        // Input change detection and set-beats-clear.
        apply_stimulus(5'd3, 8'h01);
        keys[2] = 1'b1;
        wait_irq(0, 3, found);
        check_output("key change irq", 32'(found), 1);
        read_check("inputs read", 5'd0, 8'h04);
        apply_stimulus(5'd2, 8'h01);
        check_output("change w1c", 32'(interrupts[0]), 0);
        keys[2] = 1'b0;
        repeat (2) @(negedge clk);
        apply_stimulus(5'd2, 8'h01);
        check_output("set beats w1c", 32'(interrupts[0]), 1);
        apply_stimulus(5'd2, 8'h01);
        check_output("change cleared", 32'(interrupts[0]), 0);

        // COUNT write coinciding with a tick.
        apply_stimulus(5'd4, 8'h09);
        apply_stimulus(5'd5, 8'h01);
        for (int k = 0; k < TD && (m_cyc % TD) != TD - 1; k++) @(negedge clk);
        apply_stimulus(5'd4, 8'h05);
        read_check("count write beats tick", 5'd4, 8'h05);
        check_output("leds before reset", 32'(leds), 32'h5);

        // Asynchronous reset mid-count.
        #2 reset = 1'b1;
        #1;
        check_output("async reset readdata", 32'(bus.readdata), 0);
        check_output("async reset interrupts", 32'(interrupts), 0);
        check_output("async reset leds", 32'(leds), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        read_check("post reset count", 5'd4, 8'h00);
        read_check("post reset pending", 5'd2, 8'h00);
        read_check("post reset ctrl", 5'd5, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/io_ctrl_multi.md
Name: io_ctrl_multi

Overview:
- Parametrised IO-memory controller for the processor's IO address space.
- Generalises the fixed single-timer/LED/switch-key controller:
  - N independent tick timers, each with one-shot or auto-reload mode.
  - Input-change detection on synchronised keys/switches.
  - Interrupt pending (write-1-to-clear) and enable registers.
- Sits between the core's IO read/write ports and the board peripherals; drives the core's interrupt vector.

Parameters:
- DATA_WIDTH, 8, IO data width; must be >= NUM_KEYS+NUM_SWITCHES, >= NUM_LEDS, >= NUM_TIMERS+1.
- ADDR_WIDTH, 5, IO address width.
- NUM_TIMERS, 2, number of timer channels (1..DATA_WIDTH-1).
- NUM_KEYS, 4, key inputs.
- NUM_SWITCHES, 4, switch inputs.
- NUM_LEDS, 4, LED outputs.
- TICK_DIV, 50000, clk cycles per timer tick (>=2; 1 ms at 50 MHz).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- readaddr  input  ADDR_WIDTH  IO read address.
- readdata  output  DATA_WIDTH  IO read data, registered.
- writeaddr  input  ADDR_WIDTH  IO write address.
- writedata  input  DATA_WIDTH  IO write data.
- write_en  input  1  write strobe; one write per asserted cycle.
- interrupts  output  NUM_TIMERS+1  pending & enable; bit0 = input change, bit i+1 = timer i expired.
- keys  input  NUM_KEYS  asynchronous key inputs.
- switches  input  NUM_SWITCHES  asynchronous switch inputs.
- leds  output  NUM_LEDS  LED drive.

Behaviour:
- Reset (async, active-high): all registers, counters, prescaler, synchronisers, readdata, leds, interrupts = 0.
- Register map (word addresses). Unmapped reads return 0; unmapped writes are ignored.
  - 0 INPUTS (RO): {switches_sync, keys_sync}, keys in the LSBs, zero-extended.
  - 1 LED (RW): low NUM_LEDS bits drive leds directly; reads return the register.
  - 2 IRQ_PEND (R/W1C): bit0 = change, bit i+1 = timer i.
  - 3 IRQ_EN (RW): masks IRQ_PEND onto interrupts; interrupts = IRQ_PEND & IRQ_EN, registered-free combinational AND.
  - 4+2i TMR_i_COUNT (RW): a write loads both count and reload with writedata; reads return the live count.
  - 5+2i TMR_i_CTRL (RW): bit0 RUN, bit1 RELOAD; other bits read 0.
- Read timing: readdata <= mux(readaddr) at posedge, so data is valid the cycle after readaddr is presented. Data reflects state before any same-edge write.
- Input sync: keys and switches each pass through a 2-FF synchroniser. A third register holds the previous sample. Any bit difference between current and previous sample sets IRQ_PEND[0] one cycle after the sync output changes.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick pulses for one cycle when the count equals TICK_DIV-1. Free-running from reset.
- Timer i on tick, when RUN=1:
  - count>1: count decrements.
  - count==1: count becomes 0 and IRQ_PEND[i+1] sets.
    - RELOAD=1: count <= reload; RUN stays 1. If reload==0, the timer stays at 0 and never re-fires.
    - RELOAD=0: RUN clears.
  - count==0: no change, no interrupt.
- RUN=0: count holds.
- Simultaneous events:
  - COUNT write and tick in the same cycle: the write wins; no decrement.
  - CTRL write and expiry in the same cycle: the written CTRL value wins; the pending bit still sets.
  - W1C write and a new set event on the same bit: set wins; the bit stays 1.
  - Bits written 0 in IRQ_PEND are unaffected.
- Reset mid-count clears all timers and pending bits immediately; the prescaler restarts from 0.

Test Plan:
- Reset, then read addrs 0-7 → all return 0; leds=0; interrupts=0.
- Write LED=0xA5 (NUM_LEDS=4) → leds=4'h5 next cycle; read addr1 → 0x05 one cycle after readaddr.
- TICK_DIV=4. Write TMR0_COUNT=3, CTRL=0x1, IRQ_EN=0x2 → interrupts[1]=1 after exactly 3 ticks (≤12 cycles); RUN reads 0; W1C 0x02 → interrupts[1]=0.
- TMR1 with COUNT=2, CTRL=0x3 → pending bit 2 sets every 2 ticks; count reads 2 after each expiry; no missed events over 5 periods.
- Toggle keys[2] with IRQ_EN=0x1 → interrupts[0]=1 within 3 cycles; addr0 read shows the bit. W1C on the same cycle as another toggle → bit remains 1.
- Write TMR0_COUNT=5 on a tick cycle → count reads 5 (no decrement). Assert reset mid-count → count=0, pending=0, readdata=0 immediately.
